// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// FSM state encoding, requester indices and a small index-to-grant helper.
package mem_port_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LS = 1'b1;

    localparam int CNT_W = 8;

    // Converts a requester index into its one-hot grant vector.
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        if (idx == REQ_LS) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

endpackage

// File: rtl/mux2x1.sv
// Generic two-input multiplexer used to pick the winning requester's fields.
module mux2x1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    // Select in1 when sel is set, otherwise in0.
    always_comb begin
        if (sel) begin
            out = in1;
        end else begin
            out = in0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction-fetch and a
// load/store requester, with a per-transaction timeout that aborts a stuck access.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    input  logic [1:0]       we,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [1:0]       err,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready
);

    // The abort fires in the BUSY cycle whose counter value is TIMEOUT-1,
    // so the port stays busy for exactly TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_r,     state_s;
    logic [CNT_W-1:0] cnt_r,       cnt_s;
    logic             last_r,      last_s;
    logic             owner_r,     owner_s;
    logic [1:0]       gnt_r,       gnt_s;
    logic [1:0]       done_r,      done_s;
    logic [1:0]       err_r,       err_s;
    logic [WIDTH-1:0] rdata_r,     rdata_s;
    logic             mem_req_r,   mem_req_s;
    logic             mem_we_r,    mem_we_s;
    logic [WIDTH-1:0] mem_addr_r,  mem_addr_s;
    logic [WIDTH-1:0] mem_wdata_r, mem_wdata_s;
    logic             win_s;
    logic [WIDTH-1:0] win_addr_s;
    logic [WIDTH-1:0] win_wdata_s;

    // Winner selection: a lone requester wins; on contention the one not served last.
    always_comb begin
        case (req)
            2'b01:   win_s = REQ_IF;
            2'b10:   win_s = REQ_LS;
            2'b11:   win_s = ~last_r;
            default: win_s = REQ_IF;
        endcase
    end

    mux2x1 #(.WIDTH(WIDTH)) u_addr_mux (
        .in0 (addr0),
        .in1 (addr1),
        .sel (win_s),
        .out (win_addr_s)
    );

    mux2x1 #(.WIDTH(WIDTH)) u_wdata_mux (
        .in0 (wdata0),
        .in1 (wdata1),
        .sel (win_s),
        .out (win_wdata_s)
    );

    // Next-state and next-output logic for the IDLE/BUSY controller.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        last_s      = last_r;
        owner_s     = owner_r;
        gnt_s       = gnt_r;
        done_s      = 2'b00;
        err_s       = 2'b00;
        rdata_s     = rdata_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        case (state_r)
            IDLE: begin
                if (req != 2'b00) begin
                    state_s     = BUSY;
                    cnt_s       = {CNT_W{1'b0}};
                    owner_s     = win_s;
                    gnt_s       = idx_to_onehot(win_s);
                    mem_req_s   = 1'b1;
                    mem_we_s    = we[win_s];
                    mem_addr_s  = win_addr_s;
                    mem_wdata_s = win_wdata_s;
                end else begin
                    gnt_s       = 2'b00;
                    mem_req_s   = 1'b0;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = {WIDTH{1'b0}};
                    mem_wdata_s = {WIDTH{1'b0}};
                end
            end
            BUSY: begin
                // Completion is checked first so it beats a coincident timeout.
                if (mem_ready || (cnt_r == CNT_LAST)) begin
                    state_s     = IDLE;
                    cnt_s       = {CNT_W{1'b0}};
                    last_s      = owner_r;
                    gnt_s       = 2'b00;
                    done_s      = idx_to_onehot(owner_r);
                    mem_req_s   = 1'b0;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = {WIDTH{1'b0}};
                    mem_wdata_s = {WIDTH{1'b0}};
                    if (mem_ready) begin
                        if (!mem_we_r) begin
                            rdata_s = mem_rdata;
                        end else begin
                            rdata_s = rdata_r;
                        end
                    end else begin
                        err_s   = idx_to_onehot(owner_r);
                        rdata_s = {WIDTH{1'b0}};
                    end
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s     = IDLE;
                cnt_s       = {CNT_W{1'b0}};
                gnt_s       = 2'b00;
                mem_req_s   = 1'b0;
                mem_we_s    = 1'b0;
                mem_addr_s  = {WIDTH{1'b0}};
                mem_wdata_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // State and output registers; reset abandons any transaction without a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            last_r      <= REQ_LS;
            owner_r     <= REQ_IF;
            gnt_r       <= 2'b00;
            done_r      <= 2'b00;
            err_r       <= 2'b00;
            rdata_r     <= {WIDTH{1'b0}};
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {WIDTH{1'b0}};
            mem_wdata_r <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            last_r      <= last_s;
            owner_r     <= owner_s;
            gnt_r       <= gnt_s;
            done_r      <= done_s;
            err_r       <= err_s;
            rdata_r     <= rdata_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    assign gnt       = gnt_r;
    assign done      = done_r;
    assign err       = err_r;
    assign rdata     = rdata_r;
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants and
// completions, an independent monitor pops and compares as the DUT presents them.
module tb_mem_port_arbiter;

    typedef struct {
        logic [1:0]  gnt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } grant_exp_t;

    typedef struct {
        logic [1:0]  done;
        logic [1:0]  err;
        logic [31:0] rdata;
        int          busy;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wdata0 = 32'h0, wdata1 = 32'h0;
    logic [1:0]  we = 2'b00;
    logic [1:0]  gnt, done, err;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    grant_exp_t grant_q[$];
    done_exp_t  done_q[$];

    mem_port_arbiter #(.WIDTH(32), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .we        (we),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Monitor: grant on mem_req rise, stability while busy, completion on done.
    logic        prev_req = 1'b0;
    int          busy = 0;
    grant_exp_t  cur;
    initial begin
        cur.gnt = 2'b00; cur.addr = 32'h0; cur.wdata = 32'h0; cur.we = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                busy = 0;
                if (grant_q.size() == 0) begin
                    chk("unexpected_grant", {30'h0, gnt}, 32'h0);
                end else begin
                    cur = grant_q.pop_front();
                    chk("grant_gnt", {30'h0, gnt}, {30'h0, cur.gnt});
                    chk("grant_addr", mem_addr, cur.addr);
                    chk("grant_wdata", mem_wdata, cur.wdata);
                    chk("grant_we", {31'h0, mem_we}, {31'h0, cur.we});
                end
            end
            if (mem_req) begin
                busy++;
                chk("busy_stable_addr", mem_addr, cur.addr);
                chk("busy_stable_gnt", {30'h0, gnt}, {30'h0, cur.gnt});
            end
            if (done != 2'b00) begin
                if (done_q.size() == 0) begin
                    chk("spurious_done", {30'h0, done}, 32'h0);
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    chk("done", {30'h0, done}, {30'h0, d.done});
                    chk("err", {30'h0, err}, {30'h0, d.err});
                    chk("rdata", rdata, d.rdata);
                    chk("busy_cycles", busy, d.busy);
                    chk("mem_req_at_done", {31'h0, mem_req}, 32'h0);
                    chk("gnt_at_done", {30'h0, gnt}, 32'h0);
                end
            end
            prev_req = mem_req;
        end
    end

    // One transaction: push expectations, drive requester and memory, await done.
    task automatic run(input logic [1:0] r, input logic [1:0] w,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input int ready_after, input logic [31:0] rdv,
                       input bit hold, input bit mutate,
                       input logic [1:0] eg, input logic [31:0] ea, input logic [31:0] ed,
                       input logic ewe, input logic [1:0] edn, input logic [1:0] eer,
                       input logic [31:0] erd, input int ebusy);
        grant_exp_t g;
        done_exp_t  d;
        bit         seen;
        g.gnt = eg; g.addr = ea; g.wdata = ed; g.we = ewe;
        d.done = edn; d.err = eer; d.rdata = erd; d.busy = ebusy;
        grant_q.push_back(g);
        done_q.push_back(d);
        req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        @(posedge clk); #1;
        if (!hold) req = 2'b00;
        if (mutate) begin
            addr0 = a0 ^ 32'hFF; addr1 = a1 ^ 32'hFF;
            wdata0 = ~d0; wdata1 = ~d1; we = ~w;
        end
        if (ready_after >= 0) begin
            repeat (ready_after) begin
                @(posedge clk); #1;
            end
            mem_ready = 1'b1; mem_rdata = rdv;
            @(posedge clk); #1;
            mem_ready = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done != 2'b00) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_gnt", {30'h0, gnt}, 32'h0);
        chk("rst_done_err", {28'h0, done, err}, 32'h0);
        chk("rst_mem_req_we", {30'h0, mem_req, mem_we}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);

        // Single fetch read, ready on the second BUSY cycle.
        run(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 1, 32'hA5, 0, 0,
            2'b01, 32'h10, 32'h0, 1'b0, 2'b01, 2'b00, 32'hA5, 2);
        // Load/store write: rdata must keep the previous read value.
        run(2'b10, 2'b10, 32'h0, 32'h200, 32'h0, 32'hDEAD, 0, 32'h1234, 0, 0,
            2'b10, 32'h200, 32'hDEAD, 1'b1, 2'b10, 2'b00, 32'hA5, 1);
        // Contention held: last owner was requester 1, so grants go 01,10,01,10.
        run(2'b11, 2'b00, 32'h100, 32'h104, 32'hAAAA, 32'hBBBB, 0, 32'h11, 1, 0,
            2'b01, 32'h100, 32'hAAAA, 1'b0, 2'b01, 2'b00, 32'h11, 1);
        run(2'b11, 2'b00, 32'h100, 32'h104, 32'hAAAA, 32'hBBBB, 0, 32'h22, 1, 0,
            2'b10, 32'h104, 32'hBBBB, 1'b0, 2'b10, 2'b00, 32'h22, 1);
        run(2'b11, 2'b00, 32'h100, 32'h104, 32'hAAAA, 32'hBBBB, 0, 32'h33, 1, 0,
            2'b01, 32'h100, 32'hAAAA, 1'b0, 2'b01, 2'b00, 32'h33, 1);
        run(2'b11, 2'b00, 32'h100, 32'h104, 32'hAAAA, 32'hBBBB, 0, 32'h44, 1, 0,
            2'b10, 32'h104, 32'hBBBB, 1'b0, 2'b10, 2'b00, 32'h44, 1);
        // Inputs change and req drops mid-BUSY: captured values must hold.
        run(2'b01, 2'b00, 32'h40, 32'h80, 32'h5, 32'h6, 2, 32'h77, 0, 1,
            2'b01, 32'h40, 32'h5, 1'b0, 2'b01, 2'b00, 32'h77, 3);
        // mem_ready while IDLE is ignored.
        req = 2'b00; we = 2'b00;
        mem_ready = 1'b1; mem_rdata = 32'hBAD;
        repeat (3) @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk);
        chk("idle_ready_gnt", {30'h0, gnt}, 32'h0);
        chk("idle_ready_mem_req", {31'h0, mem_req}, 32'h0);
        chk("idle_ready_rdata", rdata, 32'h77);
        // Timeout: 15 BUSY cycles, err with done, rdata cleared.
        run(2'b01, 2'b00, 32'h300, 32'h0, 32'h0, 32'h0, -1, 32'h0, 0, 0,
            2'b01, 32'h300, 32'h0, 1'b0, 2'b01, 2'b01, 32'h0, 15);
        // Ready in the same cycle as the timeout: completion wins.
        run(2'b10, 2'b00, 32'h0, 32'h400, 32'h0, 32'h0, 14, 32'h99, 0, 0,
            2'b10, 32'h400, 32'h0, 1'b0, 2'b10, 2'b00, 32'h99, 15);
        // Reset two cycles into BUSY: no done, grant state cleared.
        begin
            grant_exp_t g;
            g.gnt = 2'b10; g.addr = 32'h500; g.wdata = 32'h0; g.we = 1'b0;
            grant_q.push_back(g);
        end
        req = 2'b10; addr1 = 32'h500; wdata1 = 32'h0; we = 2'b00;
        @(posedge clk); #1 req = 2'b00;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_gnt", {30'h0, gnt}, 32'h0);
        chk("midrst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("midrst_done_err", {28'h0, done, err}, 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        // After reset requester 0 wins contention first.
        run(2'b11, 2'b00, 32'h600, 32'h604, 32'h0, 32'h0, 0, 32'h55, 0, 0,
            2'b01, 32'h600, 32'h0, 1'b0, 2'b01, 2'b00, 32'h55, 1);
        repeat (3) @(negedge clk);
        chk("grant_q_empty", grant_q.size(), 32'h0);
        chk("done_q_empty", done_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter WIDTH, 32, data/address width.
REQ-002 Parameter TIMEOUT, 15, max BUSY cycles awaiting mem_ready before abort (1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 req  input  2  request per requester; bit0 = instruction fetch, bit1 = load/store.
REQ-006 addr0, addr1  input  WIDTH  requester addresses.
REQ-007 wdata0, wdata1  input  WIDTH  requester write data.
REQ-008 we  input  2  write enable per requester.
REQ-009 gnt  output  2  one-hot owner of the memory port; 0 when idle.
REQ-010 done  output  2  one-cycle completion pulse to owner.
REQ-011 err  output  2  one-cycle timeout pulse to owner, coincident with done.
REQ-012 rdata  output  WIDTH  read data of last completed access, held until next completion.
REQ-013 mem_req, mem_we  output  1  memory-side request and write strobe.
REQ-014 mem_addr, mem_wdata  output  WIDTH  memory-side address and write data.
REQ-015 mem_rdata  input  WIDTH  memory read data.
REQ-016 mem_ready  input  1  memory completion, valid only while mem_req=1.

Function
REQ-017 FSM states IDLE and BUSY only.
REQ-018 IDLE: no req -> stay IDLE, all memory-side outputs 0.
REQ-019 IDLE, exactly one req bit set -> that requester wins.
REQ-020 IDLE, both req bits set -> winner is the requester NOT granted last (round robin); after reset, requester 0 wins first.
REQ-021 On a win, addr/wdata/we of the winner are captured into registers and FSM enters BUSY on the same edge.
REQ-022 BUSY: gnt = one-hot winner, mem_req=1, mem_addr/mem_wdata/mem_we = captured values, constant for the whole transaction.
REQ-023 Minimum latency: req sampled at edge N -> mem_req high after edge N; mem_ready sampled at edge N+1 -> done pulse after edge N+1.
REQ-024 BUSY with mem_ready=1: rdata <= mem_rdata (reads only; writes leave rdata unchanged), done[owner] pulses one cycle, last-granted <= owner, FSM -> IDLE.
REQ-025 Cycle counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
REQ-026 Counter reaching TIMEOUT without mem_ready: mem_req drops, done[owner] and err[owner] pulse, rdata <= 0, last-granted <= owner, FSM -> IDLE.
REQ-027 mem_ready and the timeout condition in the same cycle: completion wins, err stays 0.
REQ-028 Requester input changes during BUSY have no effect on the ongoing transaction.
REQ-029 Requester drops req during BUSY: transaction still completes normally.
REQ-030 Back-to-back: after done, IDLE lasts at least one cycle before the next grant.
REQ-031 mem_ready asserted while IDLE is ignored.

Reset
REQ-032 rst=1 at a clock edge: FSM -> IDLE, last-granted -> requester 1 (so requester 0 wins first), counter -> 0.
REQ-033 rst=1 at a clock edge: gnt, done, err, mem_req, mem_we -> 0, and rdata, mem_addr, mem_wdata -> 0.
REQ-034 Reset mid-BUSY abandons the transaction with no done and no err pulse.

Structure
REQ-035 Shared package holds the state encoding (IDLE=0, BUSY=1) and the requester index constants REQ_IF=0, REQ_LS=1.
REQ-036 Winner address and write-data selection uses the existing mux2x1 sub-module, one instance per field, with sel = winner index.

Verification
REQ-037 Scenario: rst, then req=01, addr0=0x10, mem_ready high 1 cycle later with mem_rdata=0xA5 -> gnt=01 for 2 cycles, mem_addr=0x10, done=01 pulse, rdata=0xA5.
REQ-038 Scenario: req=11 held continuously, mem_ready=1 every BUSY cycle -> grants alternate 01,10,01,10.
REQ-039 Scenario: req=10, we=10, wdata1=0xDEAD -> mem_we=1, mem_wdata=0xDEAD, done=10, rdata unchanged.
REQ-040 Scenario: req=01, mem_ready held 0 -> after 15 BUSY cycles err=01 and done=01 pulse together, rdata=0, mem_req=0.
REQ-041 Scenario: rst asserted 2 cycles into BUSY -> next cycle gnt=0, mem_req=0, no done; then req=11 -> gnt=01.
REQ-042 Scenario: addr0 changed mid-BUSY, or mem_ready=1 while IDLE -> mem_addr unchanged, no spurious done.
